// File: rtl/mem_fetch_pkg.sv
// Shared FSM encoding and memory-command widths for the mem_fetch byte fetcher.
package mem_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_byte_fifo.sv
// Byte FIFO for fetched instruction bytes: up to 4 bytes pushed per cycle, one popped.
module fetch_byte_fifo
  import mem_fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [2:0]             push_num_i,
  input  logic [DATA_W-1:0]      push_data_i,
  input  logic                   pop_i,
  output logic [7:0]             head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] free_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  // Flush dominates both push and pop in the same cycle.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < push_num_i) mem_q[wr_ptr_q + AW'(i)] <= push_data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(push_num_i);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (do_push ? CW'(push_num_i) : CW'(0)) - (do_pop ? CW'(1) : CW'(0));
    end
  end

  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
  assign free_o  = CW'(DEPTH) - count_q;

endmodule

// File: rtl/mem_fetch.sv
// Instruction byte fetcher: one outstanding word read at a time into a byte FIFO.
// Build option FETCH_ALIGN_EN: word-aligned reads, leading bytes dropped after redirect.
module mem_fetch
  import mem_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic [ADDR_W-1:0] out_addr,
  output logic              mem_cmd_start,
  output logic              mem_cmd_write,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_ready,
  output fetch_state_e      dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Consumer handshake: a byte transfers on a rising edge where out_valid && out_ready;
  // out_valid holds with stable byte/address until then. A redirect in that cycle cancels the pop.
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] head_addr_q, head_addr_d;
  logic              en_q, en_d;
  logic              discard_q, discard_d;
  logic              wait_first_q, wait_first_d;
  logic [1:0]        skip_q, skip_d;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        redirect_skip;
  logic              complete, push, pop, fifo_empty;
  logic [2:0]        push_num;
  logic [DATA_W-1:0] push_data;
  logic [CW-1:0]     fifo_free;

`ifdef FETCH_ALIGN_EN
  assign cmd_addr      = fetch_addr_q & ~ADDR_W'(3);
  assign redirect_skip = redirect_addr[1:0];
`else
  assign cmd_addr      = fetch_addr_q;
  assign redirect_skip = 2'd0;
`endif

  // The first WAIT cycle sees the previous response's ready still high.
  assign complete  = (state_q == WAIT) && !wait_first_q && mem_rdata_ready;
  assign pop       = !fifo_empty && out_ready && !redirect;
  assign push_num  = 3'd4 - {1'b0, skip_q};
  assign push_data = mem_rdata >> {skip_q, 3'b000};

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    en_d          = en_q;
    discard_d     = discard_q;
    wait_first_d  = 1'b0;
    skip_d        = skip_q;
    mem_cmd_start = 1'b0;
    push          = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_q && fifo_free >= CW'(4)) state_d = ISSUE;
      end
      ISSUE: begin
        // Holding start off during a redirect keeps a stale address off the bus.
        if (mem_cmd_ready && !redirect) begin
          mem_cmd_start = 1'b1;
          state_d       = WAIT;
          wait_first_d  = 1'b1;
        end
      end
      WAIT: begin
        if (complete) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          if (!discard_q && !redirect) begin
            push         = 1'b1;
            fetch_addr_d = cmd_addr + ADDR_W'(4);
            skip_d       = 2'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      fetch_addr_d = redirect_addr;
      en_d         = 1'b1;
      skip_d       = redirect_skip;
      discard_d    = (state_q == WAIT) && !complete;
    end
  end

  always_comb begin
    head_addr_d = head_addr_q;
    if (redirect)  head_addr_d = redirect_addr;
    else if (pop)  head_addr_d = head_addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      head_addr_q  <= '0;
      en_q         <= 1'b0;
      discard_q    <= 1'b0;
      wait_first_q <= 1'b0;
      skip_q       <= 2'd0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      head_addr_q  <= head_addr_d;
      en_q         <= en_d;
      discard_q    <= discard_d;
      wait_first_q <= wait_first_d;
      skip_q       <= skip_d;
    end
  end

  fetch_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect),
    .push_i      (push),
    .push_num_i  (push_num),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (out_byte),
    .empty_o     (fifo_empty),
    .free_o      (fifo_free)
  );

  assign out_valid     = !fifo_empty;
  assign out_addr      = head_addr_q;
  assign mem_addr      = cmd_addr;
  assign mem_cmd_write = 1'b0;
  assign mem_wdata     = '0;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_fetch.sv
// Directed bench for mem_fetch with a fixed-latency memory responder and byte scoreboard.
module tb_mem_fetch;
  import mem_fetch_pkg::*;

  localparam int MEM_LAT = 3;
`ifdef FETCH_ALIGN_EN
  localparam logic [31:0] EXP_CMD_102 = 32'h0000_0100;
`else
  localparam logic [31:0] EXP_CMD_102 = 32'h0000_0102;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_addr = '0;
  logic         out_ready = 1'b0;
  logic         mem_gate = 1'b1;
  logic         out_valid;
  logic [7:0]   out_byte;
  logic [31:0]  out_addr;
  logic         mem_cmd_start;
  logic         mem_cmd_write;
  logic         mem_cmd_ready;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata = '0;
  logic         mem_rdata_ready = 1'b0;
  fetch_state_e dbg_state;

  logic         mem_busy = 1'b0;
  int           mem_lat_cnt = 0;
  logic [31:0]  mem_pend = '0;
  int           mem_viol = 0;
  logic [31:0]  cmd_log[$];
  logic [7:0]   exp_q[$];
  int           n_checks = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  mem_fetch #(.FIFO_DEPTH(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect        (redirect),
    .redirect_addr   (redirect_addr),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_byte        (out_byte),
    .out_addr        (out_addr),
    .mem_cmd_start   (mem_cmd_start),
    .mem_cmd_write   (mem_cmd_write),
    .mem_cmd_ready   (mem_cmd_ready),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_rdata_ready (mem_rdata_ready),
    .dbg_state       (dbg_state)
  );

  // Memory contents: byte at address a is a[7:0] + a[15:8] - 1, so 0x100.. reads 00,01,02,03.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] + a[15:8] - 8'd1;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < cmd_log.size()) return cmd_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Responder: ready stays high one cycle past acceptance, then data after MEM_LAT cycles.
  assign mem_cmd_ready = mem_gate && !mem_busy;

  always @(posedge clk) begin
    if (mem_cmd_start) begin
      if (!mem_cmd_ready || mem_cmd_write) mem_viol <= mem_viol + 1;
      cmd_log.push_back(mem_addr);
      mem_busy    <= 1'b1;
      mem_lat_cnt <= MEM_LAT;
      mem_pend    <= mem_addr;
    end else if (mem_busy) begin
      if (mem_lat_cnt == 0) begin
        mem_busy        <= 1'b0;
        mem_rdata_ready <= 1'b1;
        mem_rdata       <= mem_word(mem_pend);
      end else begin
        mem_rdata_ready <= 1'b0;
        mem_lat_cnt     <= mem_lat_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_byte"},  32'(out_byte), 32'd0);
    check({tag, "_addr"},  out_addr, 32'd0);
    check({tag, "_start"}, 32'(mem_cmd_start), 32'd0);
    check({tag, "_maddr"}, mem_addr, 32'd0);
    check({tag, "_write"}, 32'(mem_cmd_write), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // Called at a negedge; returns at the negedge right after the redirect edge.
  task automatic do_redirect(input logic [31:0] a);
    redirect      = 1'b1;
    redirect_addr = a;
    cmd_log.delete();
    @(negedge clk);
    redirect = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic wait_state(input fetch_state_e st, input logic [31:0] a, input string tag);
    int   t = 0;
    logic hit = 1'b0;
    while (!hit && t < 100) begin
      @(negedge clk);
      t++;
      if (st == ISSUE) hit = (dbg_state == st) && (mem_addr == a);
      else             hit = (dbg_state == st) && (log_at(cmd_log.size() - 1) == a);
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  // Pops n bytes starting at a0 and compares against the memory image.
  task automatic consume(input logic [31:0] a0, input int n, input string tag);
    int         got = 0;
    int         t = 0;
    logic [7:0] eb;
    for (int i = 0; i < n; i++) exp_q.push_back(mem_byte(a0 + 32'(i)));
    out_ready = 1'b1;
    while (got < n && t < 400) begin
      if (out_valid) begin
        eb = exp_q.pop_front();
        check({tag, "_addr"}, out_addr, a0 + 32'(got));
        check({tag, "_byte"}, 32'(out_byte), 32'(eb));
        got++;
      end
      if (got < n) begin
        @(negedge clk);
        t++;
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(n));
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_fetch_before_redirect", 32'(cmd_log.size()), 32'd0);

    do_redirect(32'h100);
    consume(32'h100, 8, "seq100");
    check("seq100_cmd0", log_at(0), 32'h100);

    do_redirect(32'h300);
    repeat (60) @(negedge clk);
    check("full_cmds", 32'(cmd_log.size()), 32'd2);
    check("full_cmd1", log_at(1), 32'h304);
    check("full_valid", 32'(out_valid), 32'd1);
    consume(32'h300, 4, "drain300");
    repeat (30) @(negedge clk);
    check("refill_cmds", 32'(cmd_log.size()), 32'd3);
    check("refill_addr", log_at(2), 32'h308);
    consume(32'h304, 8, "tail300");

    do_redirect(32'h100);
    wait_state(WAIT, 32'h100, "wait100");
    do_redirect(32'h200);
    consume(32'h200, 8, "redir200");
    check("redir200_cmd0", log_at(0), 32'h200);

    mem_gate = 1'b0;
    do_redirect(32'h400);
    wait_state(ISSUE, 32'h400, "hold_issue");
    for (int i = 0; i < 5; i++) begin
      check("hold_start", 32'(mem_cmd_start), 32'd0);
      check("hold_addr", mem_addr, 32'h400);
      @(negedge clk);
    end
    mem_gate = 1'b1;
    #1;
    check("rel_start", 32'(mem_cmd_start), 32'd1);
    check("rel_addr", mem_addr, 32'h400);
    @(negedge clk);
    check("rel_start_once", 32'(mem_cmd_start), 32'd0);
    consume(32'h400, 4, "seq400");

    do_redirect(32'h102);
    consume(32'h102, 6, "seq102");
    check("align_cmd0", log_at(0), EXP_CMD_102);

    check("pop_redir_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    do_redirect(32'hFFFF_FFFC);
    consume(32'hFFFF_FFFC, 8, "wrap");
    check("wrap_cmd0", log_at(0), 32'hFFFF_FFFC);
    check("wrap_cmd1", log_at(1), 32'h0000_0000);

    do_redirect(32'h500);
    wait_state(WAIT, 32'h500, "wait500");
    rst_n = 1'b0;
    #1;
    check_reset("midwait");
    @(negedge clk);
    check_reset("midwait_hold");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_cmds", 32'(cmd_log.size()), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    do_redirect(32'h600);
    consume(32'h600, 4, "seq600");
    check("seq600_cmd0", log_at(0), 32'h600);

    check("one_outstanding", 32'(mem_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_fetch.md
MEM_FETCH -- requirements
Module: mem_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, byte-buffer depth (power of two, >=8).
REQ-002 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port redirect  input  1  one-cycle request to restart fetch at redirect_addr.
REQ-005 SHALL have port redirect_addr  input  32  new fetch byte address.
REQ-006 SHALL have port out_valid  output  1  out_byte/out_addr valid.
REQ-007 SHALL have port out_ready  input  1  consumer accepts byte.
REQ-008 SHALL have port out_byte  output  8  next instruction byte.
REQ-009 SHALL have port out_addr  output  32  address of out_byte.
REQ-010 SHALL have port mem_cmd_start  output  1  start memory command, one cycle.
REQ-011 SHALL have port mem_cmd_write  output  1  tied 0 (read-only initiator).
REQ-012 SHALL have port mem_cmd_ready  input  1  memory idle, may accept command.
REQ-013 SHALL have port mem_addr  output  32  command byte address.
REQ-014 SHALL have port mem_wdata  output  32  tied 0.
REQ-015 SHALL have port mem_rdata  input  32  read word; [7:0]=byte at mem_addr, [15:8]=+1, [23:16]=+2, [31:24]=+3.
REQ-016 SHALL have port mem_rdata_ready  input  1  read complete; holds high until next command accepted.

Function
REQ-017 SHALL use FSM IDLE, ISSUE, WAIT.
REQ-018 IDLE->ISSUE when fetch enabled (first redirect seen) and FIFO free >= 4.
REQ-019 ISSUE: drive mem_cmd_start=1, mem_addr=fetch_addr for exactly one cycle when mem_cmd_ready=1, then ->WAIT; else hold in ISSUE with start=0.
REQ-020 WAIT SHALL ignore mem_rdata_ready in the first cycle after issue (stale high); from second cycle, first sample of 1 completes.
REQ-021 On completion: push 4 bytes in address order, fetch_addr += 4 (wraps mod 2^32), ->IDLE.
REQ-022 out_valid=1 iff FIFO non-empty; pop on out_valid&&out_ready; push and pop in same cycle SHALL both occur.
REQ-023 out_addr SHALL track head-byte address, incrementing by 1 per pop, wrap mod 2^32.
REQ-024 redirect SHALL flush FIFO same edge, set fetch_addr and head address to redirect_addr; out_valid=0 next cycle.
REQ-025 redirect during WAIT SHALL set discard flag; the in-flight response is dropped, then ->IDLE refetches new address.
REQ-026 redirect during ISSUE SHALL update mem_addr before start is asserted; no stale command issued.
REQ-027 redirect and pop in same cycle: redirect wins, pop ignored.
REQ-028 Never more than one outstanding command.

Reset
REQ-029 rst_n low: state IDLE, FIFO empty, fetch disabled, discard=0, fetch_addr=0.
REQ-030 Reset outputs: out_valid=0, out_byte=0, out_addr=0, mem_cmd_start=0, mem_addr=0, mem_cmd_write=0, mem_wdata=0.
REQ-031 Reset asserted during WAIT: response abandoned; after release, first mem_rdata_ready ignored until a new command issued.

Configuration
REQ-032 Macro FETCH_ALIGN_EN defined: every mem_addr word-aligned (fetch_addr & ~3); after redirect to addr with addr%4=k, first word's k low bytes dropped, FIFO free check stays >=4.
REQ-033 FETCH_ALIGN_EN undefined: mem_addr = fetch_addr as-is (unaligned reads allowed, memory spends extra cycles).

Structure
REQ-034 Shared package SHALL hold FSM state encoding and memory-command width constants (address/data width 32).
REQ-035 Byte FIFO SHALL be sub-module fetch_byte_fifo (4-byte parallel push, 1-byte pop, flush, free count).

Verification
REQ-036 Redirect to 0x100, memory words 0x03020100: out_byte 00,01,02,03 with out_addr 0x100..0x103.
REQ-037 out_ready=0 held: exactly 2 reads (8 bytes) issued, then mem_cmd_start stays 0 until pops free 4.
REQ-038 Redirect to 0x200 while WAIT on 0x100: 0x100 data never appears; first out_addr=0x200.
REQ-039 mem_cmd_ready low 5 cycles: start held off, asserted one cycle when ready rises, mem_addr stable.
REQ-040 Redirect to 0x102 with FETCH_ALIGN_EN: mem_addr=0x100, first out_addr=0x102, byte = mem_rdata[23:16]; without macro mem_addr=0x102.
REQ-041 fetch_addr 0xFFFFFFFC: next mem_addr 0x00000000; rst_n low mid-WAIT: all outputs reset values next cycle.
